// File: rtl/pipelined_control_unit.sv
// Control unit for a 5-stage RISC-V pipeline: combinational decode in D,
// registered control for E/M/W, and a saturating count of illegal instructions.
module pipelined_control_unit #(
    parameter int EXT_BRANCH = 1,
    parameter int AUIPC_EN   = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             func7b5,
    input  logic             flushE,
    output logic [2:0]       ALUControlE,
    output logic             ALUSrcE,
    output logic             luiE,
    output logic             auipcE,
    output logic [2:0]       branchE,
    output logic [1:0]       jumpE,
    output logic [2:0]       immSrcD,
    output logic [1:0]       resultSrcE,
    output logic [1:0]       resultSrcM,
    output logic [1:0]       resultSrcW,
    output logic             regWriteM,
    output logic             regWriteW,
    output logic             memWriteM,
    output logic             illegalD,
    output logic [CNT_W-1:0] illegalCnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
        logic       lui;
        logic       auipc;
        logic [2:0] branch;
        logic [1:0] jump;
        logic       illegal;
    } ctrl_t;

    ctrl_t            ctrl_d;
    ctrl_t            ctrl_e;
    logic [1:0]       alu_op;
    logic [2:0]       imm_src;
    logic             reg_write_m, mem_write_m, reg_write_w;
    logic [1:0]       result_src_m, result_src_w;
    logic [CNT_W-1:0] illegal_cnt;

    always_comb begin
        ctrl_d  = '0;
        alu_op  = 2'b00;
        imm_src = 3'b000;
        case (opcode)
            OP_R:    begin ctrl_d.reg_write = 1'b1; alu_op = 2'b10; end
            OP_I:    begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; alu_op = 2'b11; end
            OP_LW:   begin ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.result_src = 2'b01; end
            OP_S:    begin ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1; imm_src = 3'b001; end
            OP_B: begin
                alu_op  = 2'b01;
                imm_src = 3'b010;
                case (func3)
                    3'b000:  ctrl_d.branch = 3'b001;
                    3'b001:  ctrl_d.branch = 3'b010;
                    3'b100:  ctrl_d.branch = 3'b011;
                    3'b101:  ctrl_d.branch = 3'b100;
                    3'b110:  if (EXT_BRANCH != 0) ctrl_d.branch = 3'b101; else ctrl_d.illegal = 1'b1;
                    3'b111:  if (EXT_BRANCH != 0) ctrl_d.branch = 3'b110; else ctrl_d.illegal = 1'b1;
                    default: ctrl_d.illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.jump = 2'b01; ctrl_d.result_src = 2'b10; imm_src = 3'b011;
            end
            OP_JALR: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1; ctrl_d.jump = 2'b10; ctrl_d.result_src = 2'b10;
            end
            OP_LUI: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.lui = 1'b1; ctrl_d.result_src = 2'b11; imm_src = 3'b100;
            end
            OP_AUIPC: begin
                if (AUIPC_EN != 0) begin
                    ctrl_d.reg_write = 1'b1; ctrl_d.auipc = 1'b1; ctrl_d.result_src = 2'b11; imm_src = 3'b100;
                end else begin
                    ctrl_d.illegal = 1'b1;
                end
            end
            default: ctrl_d.illegal = 1'b1;
        endcase

        // funct7 bit 5 selects sub only for register-register ops; for I-type it is immediate data
        case (alu_op)
            2'b00: ctrl_d.alu_ctrl = 3'b000;
            2'b01: ctrl_d.alu_ctrl = 3'b001;
            default: begin
                case (func3)
                    3'b000:  ctrl_d.alu_ctrl = (alu_op == 2'b10 && func7b5) ? 3'b001 : 3'b000;
                    3'b111:  ctrl_d.alu_ctrl = 3'b010;
                    3'b110:  ctrl_d.alu_ctrl = 3'b011;
                    3'b100:  ctrl_d.alu_ctrl = 3'b100;
                    3'b010:  ctrl_d.alu_ctrl = 3'b101;
                    3'b001:  ctrl_d.alu_ctrl = 3'b110;
                    3'b101:  ctrl_d.alu_ctrl = 3'b111;
                    default: ctrl_d.alu_ctrl = 3'b000;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        ctrl_e <= '0;
        else if (flushE) ctrl_e <= '0;
        else             ctrl_e <= ctrl_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
        end else begin
            reg_write_m  <= ctrl_e.reg_write;
            mem_write_m  <= ctrl_e.mem_write;
            result_src_m <= ctrl_e.result_src;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal_cnt <= '0;
        else if (ctrl_e.illegal && illegal_cnt != {CNT_W{1'b1}})
            illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign immSrcD     = imm_src;
    assign illegalD    = ctrl_d.illegal;
    assign ALUControlE = ctrl_e.alu_ctrl;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign luiE        = ctrl_e.lui;
    assign auipcE      = ctrl_e.auipc;
    assign branchE     = ctrl_e.branch;
    assign jumpE       = ctrl_e.jump;
    assign resultSrcE  = ctrl_e.result_src;
    assign resultSrcM  = result_src_m;
    assign resultSrcW  = result_src_w;
    assign regWriteM   = reg_write_m;
    assign regWriteW   = reg_write_w;
    assign memWriteM   = mem_write_m;
    assign illegalCnt  = illegal_cnt;

endmodule
